// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and helpers for the lfsr_seq_ctrl TRNG sequencer.
// The top-level macro LFSR_SEQ_CTRL_HEALTH_EN affects only the top and monitor.
package lfsr_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      LOAD,
      WARM,
      GEN,
      HOLD
   } state_t;

   localparam int SEED_W_DEF = 128;

   // Bits needed to hold every value 0..max_val inclusive.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/lfsr_rct_monitor.sv
// Repetition-count health test on the filter output stream (trip + sticky alarm).
// Compiled only when LFSR_SEQ_CTRL_HEALTH_EN is defined.
`ifdef LFSR_SEQ_CTRL_HEALTH_EN
module lfsr_rct_monitor
   import lfsr_seq_ctrl_pkg::*;
#(
   parameter int REP_LIMIT = 34
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic s_bit,
   output logic trip,
   output logic fail
);
   localparam int RUN_W = cnt_w(REP_LIMIT);

   logic [RUN_W-1:0] run_len;
   logic [RUN_W-1:0] run_nxt;
   logic             last_bit;

   // Run length saturates at the limit so a stuck source trips only once per seed.
   always_comb begin
      run_nxt = RUN_W'(1);
      if (run_len != '0 && s_bit == last_bit) begin
         run_nxt = (run_len == RUN_W'(REP_LIMIT)) ? run_len : run_len + RUN_W'(1);
      end
   end

   assign trip = en && (run_nxt == RUN_W'(REP_LIMIT)) && (run_len != RUN_W'(REP_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_len  <= '0;
         last_bit <= 1'b0;
         fail     <= 1'b0;
      end else begin
         if (clr) begin
            run_len <= '0;
         end else if (en) begin
            run_len  <= run_nxt;
            last_bit <= s_bit;
         end
         if (trip) begin
            fail <= 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/lfsr_seq_ctrl.sv
// Seed / warm-up / word-packing sequencer for the lfsr_filter TRNG post-processor.
// Define LFSR_SEQ_CTRL_HEALTH_EN to add the repetition-count health monitor on s_out.
module lfsr_seq_ctrl
   import lfsr_seq_ctrl_pkg::*;
#(
   parameter int SEED_W       = SEED_W_DEF,
   parameter int WORD_W       = 32,
   parameter int WARMUP       = 256,
   parameter int RESEED_WORDS = 1024,
   parameter int REP_LIMIT    = 34
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              raw_bit,
   input  logic              raw_valid,
   output logic [SEED_W-1:0] lfsr_p_load,
   output logic              lfsr_load,
   output logic              lfsr_en,
   input  logic              lfsr_s_out,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              health_fail
);
   localparam int CNT_MAX = (SEED_W > WARMUP) ? ((SEED_W > WORD_W) ? SEED_W : WORD_W)
                                              : ((WARMUP > WORD_W) ? WARMUP : WORD_W);
   localparam int CNT_W   = cnt_w(CNT_MAX);
   localparam int WCNT_W  = cnt_w(RESEED_WORDS);

   if (SEED_W < 1 || WORD_W < 1 || WORD_W > 64 || WARMUP < 1 || RESEED_WORDS < 1 ||
       REP_LIMIT < 2) begin : g_param_check
      $error("lfsr_seq_ctrl: parameter out of range");
   end

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [WCNT_W-1:0]   word_cnt, word_cnt_nxt;
   logic                seeded, seeded_nxt;
   logic                stop_req, stop_nxt;
   logic [SEED_W-1:0]   seed_reg;
   logic [WORD_W-1:0]   pack_reg;
   logic [WORD_W-1:0]   pack_nxt;
   logic                rct_trip;
   logic                word_done;

`ifdef LFSR_SEQ_CTRL_HEALTH_EN
   lfsr_rct_monitor #(
      .REP_LIMIT (REP_LIMIT)
   ) u_rct (
      .clk   (clk),
      .rst   (rst),
      .en    (lfsr_en),
      .clr   (lfsr_load),
      .s_bit (lfsr_s_out),
      .trip  (rct_trip),
      .fail  (health_fail)
   );
`else
   assign rct_trip    = 1'b0;
   assign health_fail = 1'b0;
`endif

   assign pack_nxt  = (pack_reg << 1) | WORD_W'(lfsr_s_out);
   assign word_done = (state == GEN) && (cnt == CNT_W'(WORD_W - 1)) && !rct_trip;

   // All handshake outputs decode the state register only: no path from out_ready.
   assign lfsr_load   = (state == LOAD);
   assign lfsr_p_load = lfsr_load ? seed_reg : '0;
   assign lfsr_en     = (state == WARM) || (state == GEN);
   assign out_valid   = (state == HOLD);
   assign busy        = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      word_cnt_nxt = word_cnt;
      seeded_nxt   = seeded;
      stop_nxt     = stop_req;
      unique case (state)
         IDLE: begin
            stop_nxt = 1'b0;
            if (run) begin
               state_nxt = seeded ? GEN : SEED;
               cnt_nxt   = '0;
            end
         end
         SEED: begin
            if (raw_valid) begin
               if (cnt == CNT_W'(SEED_W - 1)) begin
                  state_nxt = LOAD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         LOAD: begin
            seeded_nxt = 1'b1;
            state_nxt  = WARM;
            cnt_nxt    = '0;
         end
         WARM: begin
            if (cnt == CNT_W'(WARMUP - 1)) begin
               state_nxt = GEN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         GEN: begin
            if (cnt == CNT_W'(WORD_W - 1)) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (word_cnt == WCNT_W'(RESEED_WORDS - 1)) begin
                  word_cnt_nxt = '0;
                  state_nxt    = SEED;
               end else begin
                  word_cnt_nxt = word_cnt + WCNT_W'(1);
                  state_nxt    = ((stop_req || !run) && !health_fail) ? IDLE : GEN;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A stop request is remembered so the word in flight is still delivered first.
      if (!run && (state inside {SEED, LOAD, WARM, GEN})) begin
         stop_nxt = 1'b1;
      end
      if (rct_trip) begin
         state_nxt = SEED;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         word_cnt <= '0;
         seeded   <= 1'b0;
         stop_req <= 1'b0;
         out_data <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         word_cnt <= word_cnt_nxt;
         seeded   <= seeded_nxt;
         stop_req <= stop_nxt;
         if (word_done) begin
            out_data <= pack_nxt;
         end
      end
   end

   // Shift registers: stale contents are always flushed by a full fill before use.
   always_ff @(posedge clk) begin
      if (state == SEED && raw_valid) begin
         seed_reg <= (seed_reg << 1) | SEED_W'(raw_bit);
      end
      if (state == GEN) begin
         pack_reg <= pack_nxt;
      end
   end

endmodule
